// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: memop encoding, size codes, FSM states.
package mem_stage_pkg;

    // ex_memop bit positions
    localparam int unsigned MemopLoadBit  = 3;
    localparam int unsigned MemopStoreBit = 2;

    // ex_memop[1:0] access size codes
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    // Half needs 2-byte alignment, word needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SizeHalf: return addr_lo[0];
            SizeWord: return (addr_lo != 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SizeByte: return 4'b0001 << addr_lo;
            SizeHalf: return 4'b0011 << addr_lo;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half out of a memory word and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select lane by low address bits, then zero- or sign-extend by size.
    always_comb begin
        w_byte = i_rdata[8*i_addr_lo +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SizeByte: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SizeHalf: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory handshake and writeback pulse.
module mem_stage #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [3:0]        ex_memop,
    input  logic              ex_unsigned,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_regwrite,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err
);

    import mem_stage_pkg::*;

    state_e            r_state;
    state_e            w_state_d;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_sd;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_memop;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic              r_regwrite;
    logic              r_misalign;

    logic              w_ex_mem;
    logic              w_ex_misalign;
    logic              w_access;
    logic              w_is_load;
    logic              w_is_store;
    logic [DATA_W-1:0] w_load_data;

    assign w_ex_mem      = ex_memop[MemopLoadBit] | ex_memop[MemopStoreBit];
    assign w_ex_misalign = w_ex_mem & is_misaligned(ex_memop[1:0], ex_result[1:0]);
    assign w_is_load     = r_memop[MemopLoadBit];
    assign w_is_store    = r_memop[MemopStoreBit];

    // State register and EX/MEM capture; load data latched on the ack cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_result   <= '0;
            r_sd       <= '0;
            r_rdata    <= '0;
            r_memop    <= '0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && ex_valid) begin
                r_result   <= ex_result;
                r_sd       <= ex_store_data;
                r_memop    <= ex_memop;
                r_unsigned <= ex_unsigned;
                r_rd       <= ex_rd;
                r_regwrite <= ex_regwrite;
                r_misalign <= w_ex_misalign;
            end
            if (r_state == StAccess && mem_ack) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Next state: misaligned accesses skip memory and report straight from RESP.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (ex_valid) begin
                    w_state_d = (w_ex_mem && !w_ex_misalign) ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    load_align u_load_align (
        .i_rdata    (r_rdata),
        .i_addr_lo  (r_result[1:0]),
        .i_size     (r_memop[1:0]),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Memory request outputs, held from registered fields so they stay stable in ACCESS.
    always_comb begin
        w_access  = (r_state == StAccess);
        mem_req   = w_access;
        mem_we    = w_access & w_is_store;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (w_access) begin
            mem_addr = {r_result[ADDR_W-1:2], 2'b00};
            mem_be   = byte_enable(r_memop[1:0], r_result[1:0]);
            case (r_memop[1:0])
                SizeByte: mem_wdata = {4{r_sd[7:0]}};
                SizeHalf: mem_wdata = {2{r_sd[15:0]}};
                default:  mem_wdata = r_sd;
            endcase
        end
    end

    // Writeback pulse; stores, misaligned ops and loads to x0 never write the register file.
    always_comb begin
        ex_ready     = (r_state == StIdle);
        wb_valid     = (r_state == StResp);
        wb_rd        = r_rd;
        wb_data      = (w_is_load && !r_misalign) ? w_load_data : r_result;
        wb_regwrite  = wb_valid & r_regwrite & ~w_is_store & ~r_misalign &
                       ~(w_is_load & (r_rd == 5'd0));
        misalign_err = wb_valid & r_misalign;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_memop;
    logic        ex_unsigned;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        misalign_err;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        regwrite;
        logic        misalign;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_memop      (ex_memop),
        .ex_unsigned   (ex_unsigned),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_data       (wb_data),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic chk, input logic [4:0] rd,
                        input logic rw, input logic mis);
        exp_t e;
        e.data = data; e.chk_data = chk; e.rd = rd; e.regwrite = rw; e.misalign = mis;
        sb.push_back(e);
    endtask

    // Present one instruction for a single accepted cycle.
    task automatic issue(input logic [31:0] res, input logic [31:0] sd, input logic [3:0] op,
                         input logic uns, input logic [4:0] rd, input logic rw);
        @(negedge clk);
        check("ex_ready_idle", ex_ready, 1);
        ex_valid = 1'b1; ex_result = res; ex_store_data = sd;
        ex_memop = op; ex_unsigned = uns; ex_rd = rd; ex_regwrite = rw;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    // Check the request for n cycles, acking on the last one; then check the RESP cycle.
    task automatic mem_cycle(input int n, input logic [31:0] rdata, input logic [11:0] addr,
                             input logic [3:0] be, input logic we, input logic [31:0] wdata);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("mem_req_held", mem_req, 1);
            check("mem_addr", mem_addr, addr);
            check("mem_be", mem_be, be);
            check("mem_we", mem_we, we);
            if (we) check("mem_wdata", mem_wdata, wdata);
            check("ex_ready_access", ex_ready, 0);
            if (i == n - 1) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
        end
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("resp_wb_valid", wb_valid, 1);
        check("resp_no_req", mem_req, 0);
        check("resp_ex_ready", ex_ready, 0);
    endtask

    // Scoreboard: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            total++;
            assert (sb.size() != 0)
            else begin
                bad++;
                $error("FAIL wb_unexpected observed=%h expected=none", wb_data);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) check("wb_data", wb_data, e.data);
                check("wb_rd", wb_rd, e.rd);
                check("wb_regwrite", wb_regwrite, e.regwrite);
                check("misalign_err", misalign_err, e.misalign);
            end
        end
    end

    initial begin
        rst_n = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_memop = '0;
        ex_unsigned = 1'b0; ex_rd = '0; ex_regwrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_ex_ready", ex_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU op: writeback one cycle after acceptance.
        push(32'h0000_1234, 1, 5'd5, 1, 0);
        issue(32'h0000_1234, 32'h0, 4'b0000, 0, 5'd5, 1);
        @(negedge clk);
        check("alu_wb_valid", wb_valid, 1);
        check("alu_no_req", mem_req, 0);
        check("alu_ex_ready", ex_ready, 0);

        // SB 0x103, ack on third cycle.
        push(32'h0, 0, 5'd7, 0, 0);
        issue(32'h0000_0103, 32'h0000_00AB, 4'b0100, 0, 5'd7, 1);
        mem_cycle(3, 32'h0, 12'h100, 4'b1000, 1, 32'hABAB_ABAB);

        // SH 0x006 and SW 0x008.
        push(32'h0, 0, 5'd8, 0, 0);
        issue(32'h0000_0006, 32'h1234_CDEF, 4'b0101, 0, 5'd8, 1);
        mem_cycle(1, 32'h0, 12'h004, 4'b1100, 1, 32'hCDEF_CDEF);
        push(32'h0, 0, 5'd9, 0, 0);
        issue(32'h0000_0008, 32'hA5A5_5A5A, 4'b0110, 0, 5'd9, 1);
        mem_cycle(2, 32'h0, 12'h008, 4'b1111, 1, 32'hA5A5_5A5A);

        // LB / LBU addr 0x002.
        push(32'hFFFF_FF80, 1, 5'd10, 1, 0);
        issue(32'h0000_0002, 32'h0, 4'b1000, 0, 5'd10, 1);
        mem_cycle(1, 32'h0080_0000, 12'h000, 4'b0100, 0, 32'h0);
        push(32'h0000_0080, 1, 5'd11, 1, 0);
        issue(32'h0000_0002, 32'h0, 4'b1000, 1, 5'd11, 1);
        mem_cycle(2, 32'h0080_0000, 12'h000, 4'b0100, 0, 32'h0);

        // LH / LHU upper half, LH lower half positive.
        push(32'hFFFF_8001, 1, 5'd12, 1, 0);
        issue(32'h0000_0002, 32'h0, 4'b1001, 0, 5'd12, 1);
        mem_cycle(1, 32'h8001_1234, 12'h000, 4'b1100, 0, 32'h0);
        push(32'h0000_8001, 1, 5'd13, 1, 0);
        issue(32'h0000_0002, 32'h0, 4'b1001, 1, 5'd13, 1);
        mem_cycle(1, 32'h8001_1234, 12'h000, 4'b1100, 0, 32'h0);
        push(32'h0000_7FFF, 1, 5'd14, 1, 0);
        issue(32'h0000_0000, 32'h0, 4'b1001, 0, 5'd14, 1);
        mem_cycle(1, 32'h0000_7FFF, 12'h000, 4'b0011, 0, 32'h0);

        // LW with high address bits set: they must not reach mem_addr.
        push(32'hDEAD_BEEF, 1, 5'd15, 1, 0);
        issue(32'hFFFF_F104, 32'h0, 4'b1010, 0, 5'd15, 1);
        mem_cycle(1, 32'hDEAD_BEEF, 12'h104, 4'b1111, 0, 32'h0);

        // LB to x0: data returned but no register write.
        push(32'h0000_007F, 1, 5'd0, 0, 0);
        issue(32'h0000_0001, 32'h0, 4'b1000, 0, 5'd0, 1);
        mem_cycle(1, 32'h0000_7F00, 12'h000, 4'b0010, 0, 32'h0);

        // Misaligned LH 0x001 and SW 0x00A.
        push(32'h0, 0, 5'd6, 0, 1);
        issue(32'h0000_0001, 32'h0, 4'b1001, 0, 5'd6, 1);
        @(negedge clk);
        check("mis_lh_err", misalign_err, 1);
        check("mis_lh_wb", wb_valid, 1);
        check("mis_lh_no_req", mem_req, 0);
        push(32'h0, 0, 5'd4, 0, 1);
        issue(32'h0000_000A, 32'h1111_2222, 4'b0110, 0, 5'd4, 1);
        @(negedge clk);
        check("mis_sw_err", misalign_err, 1);
        check("mis_sw_no_req", mem_req, 0);
        @(negedge clk);
        check("mis_err_one_cycle", misalign_err, 0);

        // Reset while LW is in ACCESS; stray ack afterwards must be ignored.
        issue(32'h0000_0010, 32'h0, 4'b1010, 0, 5'd3, 1);
        @(negedge clk);
        check("rst_mid_req_before", mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_wb", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_no_wb", wb_valid, 0);
        check("stray_ack_idle", ex_ready, 1);
        @(negedge clk);
        check("stray_ack_no_wb2", wb_valid, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: ADDR_W, 12, byte-address width to data memory; DATA_W, 32, datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ex_valid  input  1  execute stage presents an instruction.
REQ-005 ex_ready  output  1  stage accepts an instruction this cycle.
REQ-006 ex_result  input  32  ALU result: load/store byte address, or writeback value for non-memory ops.
REQ-007 ex_store_data  input  32  rs2 value for stores.
REQ-008 ex_memop  input  4  [3]=load, [2]=store, [1:0]=size (00 byte, 01 half, 10 word); funct3[2]=unsigned carried in ex_unsigned.
REQ-009 ex_unsigned  input  1  zero-extend loads (LBU/LHU).
REQ-010 ex_rd  input  5; ex_regwrite  input  1  destination register and write enable.
REQ-011 mem_req  output  1; mem_we  output  1; mem_addr  output  ADDR_W (word-aligned, [1:0]=0); mem_be  output  4; mem_wdata  output  32.
REQ-012 mem_ack  input  1; mem_rdata  input  32  memory completes request; rdata valid with ack.
REQ-013 wb_valid  output  1; wb_rd  output  5; wb_regwrite  output  1; wb_data  output  32  one-cycle writeback pulse.
REQ-014 misalign_err  output  1  one-cycle pulse on misaligned access.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; ex_ready=1 only in IDLE.
REQ-016 IDLE, ex_valid=1: capture all ex_* into EX/MEM register; memory op -> ACCESS; otherwise -> RESP.
REQ-017 Non-memory op: wb_valid asserted exactly 1 cycle after acceptance, wb_data=ex_result, then IDLE.
REQ-018 ACCESS: mem_req held 1 from first cycle in ACCESS until and including the mem_ack cycle; mem_addr, mem_be, mem_wdata, mem_we stable throughout.
REQ-019 mem_ack in ACCESS -> RESP; load data captured from mem_rdata in that cycle; mem_ack outside ACCESS ignored.
REQ-020 Byte enables: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
REQ-021 Store data replicated: byte -> {4{sd[7:0]}}; half -> {2{sd[15:0]}}; word -> sd.
REQ-022 Load extraction: select byte/half by addr[1:0], sign-extend unless ex_unsigned; word passed unchanged.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no mem_req, misalign_err pulses and wb_valid pulses with wb_regwrite=0, one cycle after acceptance.
REQ-024 Stores: wb_valid pulses in RESP with wb_regwrite=0; loads with rd=0 force wb_regwrite=0.
REQ-025 RESP lasts exactly one cycle then IDLE; max throughput one non-memory op per 2 cycles.
REQ-026 ex_result bits above ADDR_W ignored for address generation.

Reset
REQ-027 rst_n low: state IDLE; mem_req, mem_we, wb_valid, wb_regwrite, misalign_err = 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data = 0, immediately without clock.
REQ-028 Reset mid-ACCESS abandons request; a later mem_ack after reset release is ignored.

Structure
REQ-029 Shared package holds memop encodings, size codes, and FSM state enum.
REQ-030 One sub-module, load_align: combinational byte-select and extension for loads (REQ-022).

Verification
REQ-031 ALU op, ex_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_regwrite=1, no mem_req.
REQ-032 SB addr 0x103, sd=0x000000AB -> mem_addr=0x100, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; ack after 3 cycles -> mem_req held 3 cycles, wb_regwrite=0.
REQ-033 LB addr 0x002, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 LH addr 0x001 -> misalign_err pulse, no mem_req, wb_regwrite=0.
REQ-035 LW in ACCESS, rst_n dropped -> mem_req=0 immediately; stray mem_ack after release -> no wb_valid.
